// File: rtl/mont_exp_ctrl.sv
// Modular-exponentiation sequencer: computes X^E mod M by left-to-right
// square-and-multiply, issuing every Montgomery product to an external multiplier.
module mont_exp_ctrl #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int LEN_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_e_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic [WIDTH-1:0]     mul_result,
  input  logic                 mul_done
);

  typedef enum logic [3:0] {
    IDLE,
    TOMONT_ISSUE, TOMONT_WAIT,
    SQUARE_ISSUE, SQUARE_WAIT,
    MULT_ISSUE, MULT_WAIT,
    FROMMONT_ISSUE, FROMMONT_WAIT,
    DONE_ST
  } stateE;

  stateE state, nextState;

  logic [WIDTH-1:0]     xReg, rReg, r2Reg, xmReg, accReg;
  logic [EXP_WIDTH-1:0] eReg;
  logic [LEN_W-1:0]     lenReg, idx, idxDec, lenClamped;
  logic                 waitArmed, isWait, capture, eBit;

  assign lenClamped = (in_e_len > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : in_e_len;
  assign idxDec     = idx - LEN_W'(1);
  assign eBit       = |(eReg & (EXP_WIDTH'(1) << idxDec));
  assign isWait     = (state == TOMONT_WAIT) || (state == SQUARE_WAIT) ||
                      (state == MULT_WAIT)   || (state == FROMMONT_WAIT);
  // The first WAIT cycle is skipped so a done level left over from the previous product is never counted.
  assign capture    = isWait && waitArmed && mul_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    busy      = (state != IDLE) && (state != DONE_ST);
    done      = (state == DONE_ST);
    unique case (state)
      IDLE:           if (start) nextState = TOMONT_ISSUE;
      TOMONT_ISSUE:   nextState = TOMONT_WAIT;
      TOMONT_WAIT:    if (capture) nextState = (lenReg == '0) ? FROMMONT_ISSUE : SQUARE_ISSUE;
      SQUARE_ISSUE:   nextState = SQUARE_WAIT;
      SQUARE_WAIT:
        if (capture) begin
          if (eBit)               nextState = MULT_ISSUE;
          else if (idxDec != '0)  nextState = SQUARE_ISSUE;
          else                    nextState = FROMMONT_ISSUE;
        end
      MULT_ISSUE:     nextState = MULT_WAIT;
      MULT_WAIT:      if (capture) nextState = (idx != '0) ? SQUARE_ISSUE : FROMMONT_ISSUE;
      FROMMONT_ISSUE: nextState = FROMMONT_WAIT;
      FROMMONT_WAIT:  if (capture) nextState = DONE_ST;
      DONE_ST:        nextState = IDLE;
      default:        nextState = IDLE;
    endcase
    // Operands come straight from registers that only change on capture, so they hold through the wait.
    unique case (state)
      TOMONT_ISSUE, TOMONT_WAIT:     begin mul_a = xReg;   mul_b = r2Reg;         end
      SQUARE_ISSUE, SQUARE_WAIT:     begin mul_a = accReg; mul_b = accReg;        end
      MULT_ISSUE, MULT_WAIT:         begin mul_a = accReg; mul_b = xmReg;         end
      FROMMONT_ISSUE, FROMMONT_WAIT: begin mul_a = accReg; mul_b = WIDTH'(1);     end
      default:                       begin mul_a = '0;     mul_b = '0;            end
    endcase
    mul_start = (state == TOMONT_ISSUE) || (state == SQUARE_ISSUE) ||
                (state == MULT_ISSUE)   || (state == FROMMONT_ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xReg      <= '0;
      eReg      <= '0;
      lenReg    <= '0;
      mul_m     <= '0;
      rReg      <= '0;
      r2Reg     <= '0;
      xmReg     <= '0;
      accReg    <= '0;
      idx       <= '0;
      result    <= '0;
      waitArmed <= 1'b0;
    end else begin
      waitArmed <= isWait;
      unique case (state)
        IDLE:
          if (start) begin
            xReg   <= in_x;
            eReg   <= in_e;
            lenReg <= lenClamped;
            mul_m  <= in_m;
            rReg   <= in_r;
            r2Reg  <= in_r2;
          end
        TOMONT_WAIT:
          if (capture) begin
            xmReg  <= mul_result;
            accReg <= rReg;
            idx    <= lenReg;
          end
        SQUARE_WAIT:
          if (capture) begin
            accReg <= mul_result;
            idx    <= idxDec;
          end
        MULT_WAIT:     if (capture) accReg <= mul_result;
        FROMMONT_WAIT: if (capture) result <= mul_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl at WIDTH=8: a behavioural Montgomery
// multiplier answers the products and results are compared to plain modular exponentiation.
module tb_mont_exp_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] in_x, in_e, in_m, in_r, in_r2;
  logic [3:0] in_e_len;
  logic       busy, done, mul_start;
  logic [7:0] result, mul_a, mul_b, mul_m;
  logic [7:0] mul_result = '0;
  logic       mul_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int holdLen = 1;
  int startCount = 0;
  int violations = 0;
  int curM = 0;
  int busyCnt = 0;
  int holdCnt = 0;
  int pend = 0;

  typedef struct {
    int x; int e; int len; int m; int hold; bit poke;
    int expRes; int expProducts;
  } vecT;

  vecT vecs[8];

  mont_exp_ctrl #(.WIDTH(8), .EXP_WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m),
    .in_r(in_r), .in_r2(in_r2),
    .busy(busy), .done(done), .result(result),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  function automatic int montMul(input int a, input int b, input int m);
    int rinv = 0;
    if (m < 2) return 0;
    for (int k = 1; k < m; k++) if (((256 * k) % m) == 1) rinv = k;
    return (((a * b) % m) * rinv) % m;
  endfunction

  function automatic int effLen(input int len);
    return (len > 8) ? 8 : len;
  endfunction

  function automatic int refExp(input int x, input int e, input int len, input int m);
    int acc = 1 % m;
    int base = x % m;
    for (int i = 0; i < effLen(len); i++) begin
      if (((e >> i) & 1) == 1) acc = (acc * base) % m;
      base = (base * base) % m;
    end
    return acc;
  endfunction

  function automatic int refProducts(input int e, input int len);
    int n = 2 + effLen(len);
    for (int i = 0; i < effLen(len); i++) n += (e >> i) & 1;
    return n;
  endfunction

  // Multiplier model: random 2..5 cycle latency, done held for holdLen cycles.
  always @(negedge clk) begin
    if (reset) begin
      busyCnt  = 0;
      holdCnt  = 0;
      mul_done = 1'b0;
    end else begin
      if (holdCnt > 0) begin
        holdCnt--;
        if (holdCnt == 0) mul_done = 1'b0;
      end
      if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) begin
          mul_result = 8'(pend);
          mul_done   = 1'b1;
          holdCnt    = holdLen;
        end
      end
      if (mul_start) begin
        pend    = montMul(int'(mul_a), int'(mul_b), int'(mul_m));
        busyCnt = $urandom_range(2, 5);
        startCount++;
      end
    end
  end

  always @(negedge clk)
    if (!reset && mul_start && (!busy || done || (mul_m != 8'(curM)))) violations++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic driveOperands(input vecT v);
    curM     = v.m;
    in_x     = 8'(v.x);
    in_e     = 8'(v.e);
    in_e_len = 4'(v.len);
    in_m     = 8'(v.m);
    in_r     = 8'(256 % v.m);
    in_r2    = 8'(65536 % v.m);
  endtask

  task automatic applyStimulus(input vecT v, output logic [31:0] res, output int products,
                               output int doneCycles, output int busyAfter, output bit timedOut);
    int sBase;
    holdLen = v.hold;
    @(negedge clk);
    sBase = startCount;
    driveOperands(v);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    busyAfter = int'(busy);
    timedOut  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        timedOut = 1'b0;
        break;
      end
      if (v.poke) begin
        start = 1'($urandom_range(0, 1));
        in_x  = 8'($urandom);
        in_e  = 8'($urandom);
        in_m  = 8'($urandom);
      end
      @(negedge clk);
    end
    start      = 1'b0;
    doneCycles = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) doneCycles++;
      @(negedge clk);
    end
    res      = 32'(result);
    products = startCount - sBase;
  endtask

  task automatic runVec(input string tag, input vecT v);
    logic [31:0] res;
    int products, doneCycles, busyAfter, vBase;
    bit timedOut;
    vBase = violations;
    applyStimulus(v, res, products, doneCycles, busyAfter, timedOut);
    checkOutput($sformatf("%s timeout", tag), 32'(timedOut), 0);
    checkOutput($sformatf("%s busy", tag), busyAfter, 1);
    checkOutput($sformatf("%s result", tag), res, v.expRes);
    checkOutput($sformatf("%s products", tag), products, v.expProducts);
    checkOutput($sformatf("%s doneWidth", tag), doneCycles, 1);
    checkOutput($sformatf("%s mulStartRules", tag), violations - vBase, 0);
  endtask

  initial begin
    vecT v;
    int sBase, n;
    reset = 1'b1; start = 1'b0;
    in_x = '0; in_e = '0; in_e_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset mul_start", mul_start, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset mul_a", mul_a, 0);
    checkOutput("reset mul_b", mul_b, 0);
    checkOutput("reset mul_m", mul_m, 0);
    reset = 1'b0;

    //            x   e     len m   hold poke res products
    vecs[0] = '{  2, 5,     3, 13,  1,  0,   6,  7 };
    vecs[1] = '{  7, 'h5A,  0, 13,  1,  0,   1,  2 };
    vecs[2] = '{  0, 'hFF,  8, 13,  1,  0,   0, 18 };
    vecs[3] = '{  2, 5,     3, 13,  3,  0,   6,  7 };
    vecs[4] = '{  2, 5,     3, 13,  1,  1,   6,  7 };
    vecs[5] = '{  2, 'hF5,  3, 13,  2,  0,   6,  7 };
    vecs[6] = '{  2, 'h03, 15, 13,  1,  0,   8, 12 };
    vecs[7] = '{ 12, 'h80,  8, 13,  3,  1,   1, 11 };
    for (int i = 0; i < 8; i++) runVec($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of a run, then a clean rerun of the first vector.
    holdLen = 1;
    @(negedge clk);
    sBase = startCount;
    driveOperands(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((startCount - sBase) < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrun reached", 32'(n < 500), 1);
    reset = 1'b1;
    #1;
    checkOutput("midrun reset busy", busy, 0);
    checkOutput("midrun reset done", done, 0);
    checkOutput("midrun reset mul_start", mul_start, 0);
    checkOutput("midrun reset result", result, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    runVec("after reset", vecs[0]);

    for (int i = 0; i < 20; i++) begin
      v.m    = 2 * $urandom_range(1, 127) + 1;
      v.x    = $urandom_range(0, v.m - 1);
      v.e    = $urandom_range(0, 255);
      v.len  = $urandom_range(0, 15);
      v.hold = $urandom_range(1, 3);
      v.poke = 1'($urandom_range(0, 1));
      v.expRes      = refExp(v.x, v.e, v.len, v.m);
      v.expProducts = refProducts(v.e, v.len);
      runVec($sformatf("rand%0d", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
